// File: rtl/lock_pkg.sv
// Shared types and defaults for the digital lock controller.
//   lock_state_t      : sequencing FSM state encoding
//   DIGIT_W_DEF       : default bits per keypad digit
//   CODE_LEN_DEF      : default digits per code
//   DEFAULT_CODE_DEF  : code loaded on reset
package lock_pkg;

    localparam int unsigned DIGIT_W_DEF  = 4;
    localparam int unsigned CODE_LEN_DEF = 4;
    localparam logic [CODE_LEN_DEF*DIGIT_W_DEF-1:0] DEFAULT_CODE_DEF = 16'h1234;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_SET_CODE = 3'd3,
        ST_LOCKOUT  = 3'd4
    } lock_state_t;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter that times the wrong-code lockout.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   load  : loads CYCLES-1 into the counter
//   done  : registered, high while the counter sits at zero
module lockout_timer #(
    parameter int unsigned CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(CYCLES);

    logic [CNT_W-1:0] count;

    // done is kept equal to (count == 0); CYCLES >= 2 so a load never lands on zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b1;
        end else if (load) begin
            count <= CNT_W'(CYCLES - 1);
            done  <= 1'b0;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
            done  <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/lock_controller.sv
// Sequencing FSM of the digital lock: buffers keypad digits, checks them
// against the stored code, tracks failed attempts, drives lockout and
// supports changing the code while unlocked.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   digit_valid  : pulse, digit is valid
//   digit        : keypad value
//   enter/clear  : pulse, submit / discard buffer
//   lock_btn     : pulse, relock
//   set_code     : pulse, start code change (UNLOCKED only)
//   unlocked     : registered, high in UNLOCKED and SET_CODE
//   lockout      : registered, high during lockout
//   error        : registered one-cycle pulse on rejected submit
//   digit_count  : registered number of buffered digits
module lock_controller
    import lock_pkg::*;
#(
    parameter int unsigned CODE_LEN       = CODE_LEN_DEF,
    parameter int unsigned DIGIT_W        = DIGIT_W_DEF,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = DEFAULT_CODE_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          digit_valid,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic                          enter,
    input  logic                          clear,
    input  logic                          lock_btn,
    input  logic                          set_code,
    output logic                          unlocked,
    output logic                          lockout,
    output logic                          error,
    output logic [$clog2(CODE_LEN+1)-1:0] digit_count
);

    localparam int unsigned BUF_W = CODE_LEN * DIGIT_W;
    localparam int unsigned CNT_W = $clog2(CODE_LEN + 1);
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(CODE_LEN);
    localparam logic [TRY_W-1:0] T_MAX = TRY_W'(MAX_TRIES);

    lock_state_t      state, state_n;
    logic [BUF_W-1:0] buffer, buffer_n;
    logic [CNT_W-1:0] count_n;
    logic [BUF_W-1:0] code, code_n;
    logic [TRY_W-1:0] tries, tries_n, tries_inc;
    logic             error_n;
    logic             fail;
    logic             timer_load;
    logic             timer_done;

    lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .done  (timer_done)
    );

    assign tries_inc = tries + TRY_W'(1);

    // State register and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_LOCKED;
            buffer      <= '0;
            digit_count <= '0;
            code        <= DEFAULT_CODE;
            tries       <= '0;
            error       <= 1'b0;
            unlocked    <= 1'b0;
            lockout     <= 1'b0;
        end else begin
            state       <= state_n;
            buffer      <= buffer_n;
            digit_count <= count_n;
            code        <= code_n;
            tries       <= tries_n;
            error       <= error_n;
            unlocked    <= (state_n == ST_UNLOCKED) || (state_n == ST_SET_CODE);
            lockout     <= (state_n == ST_LOCKOUT);
        end
    end

    // Next-state logic; inputs are resolved strictly by priority
    // clear > lock_btn > enter > set_code > digit_valid, even when the
    // winning input has no effect in the current state.
    always_comb begin
        state_n    = state;
        buffer_n   = buffer;
        count_n    = digit_count;
        code_n     = code;
        tries_n    = tries;
        error_n    = 1'b0;
        fail       = 1'b0;
        timer_load = 1'b0;

        case (state)
            ST_LOCKED: begin
                if (clear || lock_btn) begin
                    buffer_n = '0;
                    count_n  = '0;
                end else if (enter) begin
                    fail = 1'b1;
                end else if (set_code) begin
                    state_n = ST_LOCKED;
                end else if (digit_valid) begin
                    state_n  = ST_ENTRY;
                    buffer_n = BUF_W'(digit);
                    count_n  = CNT_W'(1);
                end
            end

            ST_ENTRY: begin
                if (clear || lock_btn) begin
                    state_n  = ST_LOCKED;
                    buffer_n = '0;
                    count_n  = '0;
                end else if (enter) begin
                    if ((digit_count == FULL) && (buffer == code)) begin
                        state_n  = ST_UNLOCKED;
                        buffer_n = '0;
                        count_n  = '0;
                        tries_n  = '0;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (set_code) begin
                    state_n = ST_ENTRY;
                end else if (digit_valid && (digit_count != FULL)) begin
                    buffer_n = BUF_W'({buffer, digit});
                    count_n  = digit_count + CNT_W'(1);
                end
            end

            ST_UNLOCKED: begin
                if (clear) begin
                    state_n = ST_UNLOCKED;
                end else if (lock_btn) begin
                    state_n  = ST_LOCKED;
                    buffer_n = '0;
                    count_n  = '0;
                end else if (enter) begin
                    state_n = ST_UNLOCKED;
                end else if (set_code) begin
                    state_n  = ST_SET_CODE;
                    buffer_n = '0;
                    count_n  = '0;
                end
            end

            ST_SET_CODE: begin
                if (clear || lock_btn || enter) begin
                    state_n  = lock_btn && !clear ? ST_LOCKED : ST_UNLOCKED;
                    buffer_n = '0;
                    count_n  = '0;
                    if (enter && !clear && !lock_btn) begin
                        if (digit_count == FULL) begin
                            code_n = buffer;
                        end else begin
                            error_n = 1'b1;
                        end
                    end
                end else if (set_code) begin
                    state_n = ST_SET_CODE;
                end else if (digit_valid && (digit_count != FULL)) begin
                    buffer_n = BUF_W'({buffer, digit});
                    count_n  = digit_count + CNT_W'(1);
                end
            end

            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_n = ST_LOCKED;
                    tries_n = '0;
                end
            end

            default: begin
                state_n  = ST_LOCKED;
                buffer_n = '0;
                count_n  = '0;
            end
        endcase

        // Failed attempt from LOCKED or ENTRY
        if (fail) begin
            error_n  = 1'b1;
            buffer_n = '0;
            count_n  = '0;
            tries_n  = tries_inc;
            if (tries_inc >= T_MAX) begin
                state_n    = ST_LOCKOUT;
                timer_load = 1'b1;
            end else begin
                state_n = ST_LOCKED;
            end
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Directed self-checking bench for lock_controller.
module tb_lock_controller;

    localparam int unsigned L = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = '0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       lock_btn = 1'b0;
    logic       set_code = 1'b0;
    logic       unlocked;
    logic       lockout;
    logic       error;
    logic [2:0] digit_count;

    int errors = 0;
    int checks = 0;

    lock_controller #(
        .CODE_LEN       (4),
        .DIGIT_W        (4),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (L),
        .DEFAULT_CODE   (16'h1234)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .enter       (enter),
        .clear       (clear),
        .lock_btn    (lock_btn),
        .set_code    (set_code),
        .unlocked    (unlocked),
        .lockout     (lockout),
        .error       (error),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs across a rising edge; returns at the next falling edge
    task automatic pulse(input logic dv, input logic [3:0] d, input logic en,
                         input logic cl, input logic lk, input logic sc);
        digit_valid = dv;
        digit       = d;
        enter       = en;
        clear       = cl;
        lock_btn    = lk;
        set_code    = sc;
        @(negedge clk);
        digit_valid = 1'b0;
        enter       = 1'b0;
        clear       = 1'b0;
        lock_btn    = 1'b0;
        set_code    = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        pulse(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_enter();
        pulse(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_lock();
        pulse(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic press_set();
        pulse(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic type_code(input logic [15:0] c);
        key(c[15:12]);
        key(c[11:8]);
        key(c[7:4]);
        key(c[3:0]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_unlocked"}, 32'(unlocked), 32'd0);
        check({tag, "_lockout"},  32'(lockout),  32'd0);
        check({tag, "_error"},    32'(error),    32'd0);
        check({tag, "_count"},    32'(digit_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  len;
        logic err_seen;

        @(negedge clk);
        do_reset();
        check_reset_outputs("reset");

        // Correct default code
        type_code(16'h1234);
        check("count_full", 32'(digit_count), 32'd4);
        press_enter();
        check("unlock1", 32'(unlocked), 32'd1);
        check("unlock1_err", 32'(error), 32'd0);
        check("unlock1_cnt", 32'(digit_count), 32'd0);
        press_lock();
        check("relock", 32'(unlocked), 32'd0);

        // Wrong code then right code
        type_code(16'h1235);
        press_enter();
        check("wrong_err", 32'(error), 32'd1);
        check("wrong_unl", 32'(unlocked), 32'd0);
        check("wrong_cnt", 32'(digit_count), 32'd0);
        @(negedge clk);
        check("err_one_cycle", 32'(error), 32'd0);
        type_code(16'h1234);
        press_enter();
        check("unlock2", 32'(unlocked), 32'd1);
        press_lock();

        // Tries cleared by unlock: two more failures must not lock out
        type_code(16'h0000);
        press_enter();
        type_code(16'h1111);
        press_enter();
        check("two_fail_no_lockout", 32'(lockout), 32'd0);
        type_code(16'h1234);
        press_enter();
        check("unlock3", 32'(unlocked), 32'd1);
        press_lock();

        // Three failures -> lockout of exactly L cycles, inputs ignored
        type_code(16'h5555);
        press_enter();
        type_code(16'h6666);
        press_enter();
        press_enter();
        check("lockout_on", 32'(lockout), 32'd1);
        check("lockout_err", 32'(error), 32'd1);
        len = 1;
        err_seen = 1'b0;
        for (int i = 0; i < int'(L) + 10; i++) begin
            if (i % 2 == 0) key(4'h1);
            else            press_enter();
            if (!lockout) break;
            len++;
            if (error || digit_count != 3'd0 || unlocked) err_seen = 1'b1;
        end
        check("lockout_len", 32'(len), 32'(L));
        check("lockout_ignored", 32'(err_seen), 32'd0);
        check("after_lockout_err", 32'(error), 32'd0);
        type_code(16'h1234);
        press_enter();
        check("unlock_after_lockout", 32'(unlocked), 32'd1);

        // Change code to 9876
        press_set();
        check("setcode_unl", 32'(unlocked), 32'd1);
        type_code(16'h9876);
        check("setcode_cnt", 32'(digit_count), 32'd4);
        press_enter();
        check("setcode_done_unl", 32'(unlocked), 32'd1);
        check("setcode_done_err", 32'(error), 32'd0);
        press_lock();
        check("setcode_relock", 32'(unlocked), 32'd0);
        type_code(16'h1234);
        press_enter();
        check("old_code_rej", 32'(error), 32'd1);
        check("old_code_unl", 32'(unlocked), 32'd0);
        type_code(16'h9876);
        press_enter();
        check("new_code_ok", 32'(unlocked), 32'd1);

        // Short entry in SET_CODE: error, code unchanged, stay unlocked
        press_set();
        key(4'h5);
        press_enter();
        check("short_set_err", 32'(error), 32'd1);
        check("short_set_unl", 32'(unlocked), 32'd1);
        press_lock();
        type_code(16'h9876);
        press_enter();
        check("code_kept", 32'(unlocked), 32'd1);

        // Reset during SET_CODE restores default code
        press_set();
        key(4'h1);
        key(4'h2);
        do_reset();
        check_reset_outputs("rst_setcode");
        type_code(16'h1234);
        press_enter();
        check("default_after_rst", 32'(unlocked), 32'd1);
        press_lock();

        // Fifth digit ignored, count saturates
        type_code(16'h1234);
        key(4'h7);
        check("sat_cnt", 32'(digit_count), 32'd4);
        press_enter();
        check("sat_unlock", 32'(unlocked), 32'd1);
        press_lock();

        // clear beats enter in the same cycle
        key(4'h1);
        key(4'h2);
        pulse(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_enter_err", 32'(error), 32'd0);
        check("clr_enter_cnt", 32'(digit_count), 32'd0);
        check("clr_enter_unl", 32'(unlocked), 32'd0);

        // Reset during lockout
        press_enter();
        press_enter();
        press_enter();
        check("lockout2_on", 32'(lockout), 32'd1);
        @(negedge clk);
        @(negedge clk);
        do_reset();
        check_reset_outputs("rst_lockout");
        type_code(16'h1234);
        press_enter();
        check("unlock_after_rst", 32'(unlocked), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
